// File: rtl/reed_speed_meter_if.sv
// reed_speed_meter_if: reed input, wheel circumference and speed/status outputs
interface reed_speed_meter_if;
  logic       reed;
  logic [7:0] circ;
  logic [6:0] speed;
  logic [6:0] max_speed;
  logic       moving;
  logic       speed_valid;
  modport master (output reed, circ, input speed, max_speed, moving, speed_valid);
  modport slave (input reed, circ, output speed, max_speed, moving, speed_valid);
endinterface

// File: rtl/reed_speed_meter.sv
// reed_speed_meter: wheel period measurement and restoring-divider km/h conversion
module reed_speed_meter #(
  parameter int CLK_HZ    = 2048,
  parameter int TO_MULT   = 25,
  parameter int SPEED_MAX = 99,
  parameter int DIV_W     = 22
) (
  input logic             clock,
  input logic             reset,
  reed_speed_meter_if.slave bus
);
  // circ*CLK_HZ*36/(1000*P) reduced to circ*NUM_K/(125*P)
  localparam int NUM_K = CLK_HZ * 9 / 2;
  typedef enum logic {STOPPED, MOVING} mstate_t;
  typedef enum logic {DIV_IDLE, DIV_RUN} dstate_t;
  mstate_t st, st_n;
  dstate_t ds, ds_n;
  logic             reed_q;
  logic [12:0]      cnt, pend_p, thr, op_p;
  logic [7:0]       pend_c, op_c;
  logic             pend_v;
  logic [DIV_W-1:0] quo, q_fin;
  logic [19:0]      den, rem, rem_n;
  logic [20:0]      trial;
  logic [4:0]       it;
  logic [6:0]       speed, max_speed, sat;
  logic             speed_valid;
  logic             rise, tmo, cap, start_new, start_pend, last, qbit;
  assign rise = bus.reed & ~reed_q;
  assign thr = 13'(bus.circ) * 13'(TO_MULT);
  always_comb begin
    tmo = st == MOVING && !rise && cnt > thr;
    cap = st == MOVING && rise;
    start_new = cap && ds == DIV_IDLE;
    start_pend = st == MOVING && !rise && !tmo && ds == DIV_IDLE && pend_v;
    last = ds == DIV_RUN && it == 5'(DIV_W - 1);
    op_p = start_pend ? pend_p : cnt;
    op_c = start_pend ? pend_c : bus.circ;
    st_n = (st == STOPPED && rise) ? MOVING : tmo ? STOPPED : st;
    ds_n = tmo ? DIV_IDLE : (start_new || start_pend) ? DIV_RUN : last ? DIV_IDLE : ds;
  end
  // one restoring step: remainder stays below den, so trial[20] only matters in the compare
  always_comb begin
    trial = {rem, quo[DIV_W-1]};
    qbit = trial >= {1'b0, den};
    rem_n = qbit ? 20'(trial - {1'b0, den}) : trial[19:0];
    q_fin = {quo[DIV_W-2:0], qbit};
    sat = q_fin > DIV_W'(SPEED_MAX) ? 7'(SPEED_MAX) : q_fin[6:0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= STOPPED;
      ds <= DIV_IDLE;
      reed_q <= 1'b0;
      cnt <= '0;
      pend_v <= 1'b0;
      pend_p <= '0;
      pend_c <= '0;
      quo <= '0;
      den <= '0;
      rem <= '0;
      it <= '0;
      speed <= '0;
      max_speed <= '0;
      speed_valid <= 1'b0;
    end else begin
      st <= st_n;
      ds <= ds_n;
      reed_q <= bus.reed;
      cnt <= rise ? 13'd1 : (&cnt) ? cnt : cnt + 13'd1;
      speed_valid <= 1'b0;
      if (start_new || start_pend) begin
        quo <= DIV_W'(op_c) * DIV_W'(NUM_K);
        den <= 20'(op_p) * 20'd125;
        rem <= '0;
        it <= '0;
      end else if (ds == DIV_RUN) begin
        quo <= q_fin;
        rem <= rem_n;
        it <= it + 5'd1;
      end
      if (cap && ds == DIV_RUN) begin
        pend_p <= cnt;
        pend_c <= bus.circ;
        pend_v <= 1'b1;
      end else if (tmo || start_new || start_pend) pend_v <= 1'b0;
      if (tmo) speed <= '0;
      else if (last) begin
        speed <= sat;
        speed_valid <= 1'b1;
      end
      if (speed > max_speed) max_speed <= speed;
    end
  end
  assign bus.speed = speed;
  assign bus.max_speed = max_speed;
  assign bus.moving = st == MOVING;
  assign bus.speed_valid = speed_valid;
endmodule

// File: tb/tb_reed_speed_meter.sv
// tb_reed_speed_meter: directed reed-period scenarios with hand-computed speeds
module tb_reed_speed_meter;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  reed_speed_meter_if bus();
  reed_speed_meter dut (.clock(clock), .reset(reset), .bus(bus));
  int errors = 0, checks = 0, t = 0, cyc = 0, nvalid = 0, n5 = 0, lastv = -1, nv = 0;
  bit mon = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      t++;
    end
  endtask
  task automatic tick_to(input int k);
    tick(k - t);
  endtask
  task automatic pulse();
    bus.reed = 1'b1;
    t = 0;
    tick(1);
    bus.reed = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.reed = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask
  always @(negedge clock) begin
    cyc++;
    if (bus.speed_valid) begin
      nvalid++;
      if (mon) begin
        n5++;
        check("t5_speed", bus.speed, 92);
        if (lastv >= 0) check("t5_gap_ge23", cyc - lastv >= 23, 1);
        lastv = cyc;
      end
    end
  end
  initial begin
    bus.reed = 1'b0;
    bus.circ = 8'd255;
    @(negedge clock);
    do_reset();
    check("rst_speed", bus.speed, 0);
    check("rst_max", bus.max_speed, 0);
    check("rst_moving", bus.moving, 0);
    check("rst_valid", bus.speed_valid, 0);
    // 1: circ=255, period 256 -> 73
    pulse();
    check("t1_moving", bus.moving, 1);
    check("t1_speed0", bus.speed, 0);
    tick_to(256);
    pulse();
    tick_to(22);
    check("t1_valid_early", bus.speed_valid, 0);
    tick_to(23);
    check("t1_valid", bus.speed_valid, 1);
    check("t1_speed", bus.speed, 73);
    tick_to(24);
    check("t1_valid_off", bus.speed_valid, 0);
    check("t1_max", bus.max_speed, 73);
    // 2: circ=200, periods 1000/200/1000 -> 14/73/14
    do_reset();
    check("t2_rst_max", bus.max_speed, 0);
    bus.circ = 8'd200;
    pulse();
    tick_to(1000);
    pulse();
    tick_to(24);
    check("t2_speed14", bus.speed, 14);
    check("t2_max14", bus.max_speed, 14);
    tick_to(200);
    pulse();
    tick_to(24);
    check("t2_speed73", bus.speed, 73);
    check("t2_max73", bus.max_speed, 73);
    tick_to(1000);
    pulse();
    tick_to(24);
    check("t2_speed14b", bus.speed, 14);
    check("t2_max_keep", bus.max_speed, 73);
    // 3: circ=255, period 100 -> quotient 188 saturates
    bus.circ = 8'd255;
    tick_to(100);
    pulse();
    tick_to(24);
    check("t3_speed_sat", bus.speed, 99);
    check("t3_max_sat", bus.max_speed, 99);
    // 4: circ=200 timeout at cnt=5001
    bus.circ = 8'd200;
    tick_to(1000);
    pulse();
    tick_to(24);
    check("t4_speed14", bus.speed, 14);
    nv = nvalid;
    tick_to(5001);
    check("t4_moving_hold", bus.moving, 1);
    check("t4_speed_hold", bus.speed, 14);
    tick_to(5002);
    check("t4_stopped", bus.moving, 0);
    check("t4_speed0", bus.speed, 0);
    check("t4_max_keep", bus.max_speed, 99);
    tick_to(5100);
    check("t4_no_valid", nvalid, nv);
    pulse();
    check("t4_remove", bus.moving, 1);
    tick_to(30);
    check("t4_speed_still0", bus.speed, 0);
    check("t4_no_div", nvalid, nv);
    tick_to(1000);
    pulse();
    tick_to(23);
    check("t4_valid", bus.speed_valid, 1);
    check("t4_speed14b", bus.speed, 14);
    // 5: circ=10, period 8 -> pending slot, results 92 at 23-cycle spacing
    do_reset();
    bus.circ = 8'd10;
    mon = 1'b1;
    pulse();
    for (int i = 0; i < 12; i++) begin
      tick_to(8);
      pulse();
    end
    tick(100);
    mon = 1'b0;
    check("t5_count", n5, 5);
    check("t5_max", bus.max_speed, 92);
    check("t5_moving", bus.moving, 1);
    // 6: reset 10 cycles into a division
    bus.circ = 8'd200;
    tick(10);
    pulse();
    tick_to(10);
    nv = nvalid;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_speed", bus.speed, 0);
    check("t6_max", bus.max_speed, 0);
    check("t6_moving", bus.moving, 0);
    check("t6_valid", bus.speed_valid, 0);
    tick(30);
    check("t6_no_valid", nvalid, nv);
    pulse();
    check("t6_remove", bus.moving, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
